// File: rtl/pic_alu_pkg.sv
// Shared ALU definitions: sequencer states, adder OP encodings and status-bit positions.
package pic_alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_WB      = 2'd3
  } seq_state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int STAT_C  = 0;
  localparam int STAT_DC = 1;
  localparam int STAT_Z  = 2;
  localparam int STAT_W  = 3;

endpackage

// File: rtl/pic_status_flags.sv
// Combinational PIC C/DC/Z derivation from an adder result and its operands.
module pic_status_flags
  import pic_alu_pkg::*;
(
  input  logic [7:0]        sum,
  input  logic              cout,
  input  logic              a4,
  input  logic              b4,
  input  logic              op,
  output logic [STAT_W-1:0] flags
);

  // Only bit 4 of the operands matters: DC is the carry into bit 4, recovered
  // from the sum bit and the (possibly inverted) operand bits.
  always_comb begin
    flags          = '0;
    flags[STAT_C]  = cout;
    flags[STAT_DC] = sum[4] ^ a4 ^ (b4 ^ op);
    flags[STAT_Z]  = (sum == 8'h00);
  end

endmodule

// File: rtl/pic_addsub_sequencer.sv
// Sequencer around the external 8-bit ripple add/sub unit: owns W and the C/DC/Z
// flags, holds adder operands for a programmable settle time, then captures.
module pic_addsub_sequencer
  import pic_alu_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [7:0] W_RESET       = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_op,
  input  logic       req_ldw,
  input  logic       req_d,
  input  logic [7:0] req_f,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_op,
  input  logic [7:0] add_sum,
  input  logic       add_cout,
  output logic       wb_valid,
  input  logic       wb_ready,
  output logic [7:0] wb_data,
  output logic [7:0] w_q,
  output logic       status_c,
  output logic       status_dc,
  output logic       status_z,
  output logic       busy
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  seq_state_t        state_reg, state_next;
  logic [3:0]        cnt_reg;
  logic [7:0]        f_reg, w_reg, wb_data_reg;
  logic              op_reg, d_reg;
  logic              c_reg, dc_reg, z_reg;
  logic              accept;
  logic [STAT_W-1:0] flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Ready and valid are pure state decodes; no path from req_valid or wb_ready.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    wb_valid   = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
        if (req_valid && !req_ldw) state_next = ST_SETTLE;
      end
      ST_SETTLE:  if (cnt_reg == 4'd0) state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = d_reg ? ST_WB : ST_IDLE;
      ST_WB: begin
        wb_valid = 1'b1;
        if (wb_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  pic_status_flags u_flags (
    .sum   (add_sum),
    .cout  (add_cout),
    .a4    (f_reg[4]),
    .b4    (w_reg[4]),
    .op    (op_reg),
    .flags (flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= 4'd0;
      f_reg       <= 8'h00;
      op_reg      <= OP_ADD;
      d_reg       <= 1'b0;
      w_reg       <= W_RESET;
      wb_data_reg <= 8'h00;
      c_reg       <= 1'b0;
      dc_reg      <= 1'b0;
      z_reg       <= (W_RESET == 8'h00);
    end else begin
      if (accept) begin
        if (req_ldw) begin
          w_reg <= req_f;
          z_reg <= (req_f == 8'h00);
        end else begin
          f_reg   <= req_f;
          op_reg  <= req_op;
          d_reg   <= req_d;
          cnt_reg <= SETTLE_LOAD;
        end
      end
      if (state_reg == ST_SETTLE && cnt_reg != 4'd0) cnt_reg <= cnt_reg - 4'd1;
      if (state_reg == ST_CAPTURE) begin
        c_reg  <= flags[STAT_C];
        dc_reg <= flags[STAT_DC];
        z_reg  <= flags[STAT_Z];
        if (d_reg) wb_data_reg <= add_sum;
        else       w_reg       <= add_sum;
      end
    end
  end

  // W feeds the adder B port directly; it cannot change while busy.
  assign add_a     = f_reg;
  assign add_b     = w_reg;
  assign add_op    = op_reg;
  assign wb_data   = wb_data_reg;
  assign w_q       = w_reg;
  assign status_c  = c_reg;
  assign status_dc = dc_reg;
  assign status_z  = z_reg;
  assign busy      = !req_ready;

endmodule
